// File: rtl/mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// mult_seq_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   W_DEFAULT  default operand width (product is 2*W bits)
//   ACC_W      accumulator width for the default operand width (2*W+1)
//   STEP_W     step-counter width for the default operand width
//   state_e    one-hot controller state encoding
//   col_kept   truncation rule: a product column survives when col >= k
// -----------------------------------------------------------------------------
package mult_seq_pkg;

  localparam int W_DEFAULT = 8;
  localparam int ACC_W     = 2 * W_DEFAULT + 1;
  localparam int STEP_W    = $clog2(W_DEFAULT + 1);

  // One-hot so each status output is a single flop bit.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_DONE = 3'b100
  } state_e;

  // A partial-product bit landing in column col is kept only when col >= k.
  function automatic logic col_kept(input int col, input logic [3:0] k);
    logic keep;
    if (col >= int'(k)) begin
      keep = 1'b1;
    end else begin
      keep = 1'b0;
    end
    return keep;
  endfunction

endpackage

// File: rtl/shift_add_mult_seq_add_row.sv
// -----------------------------------------------------------------------------
// add_row
// W-bit ripple-carry adder built from W one-bit full-adder cells.
// The chain carry-in is tied low; the final carry leaves on cout.
// Ports:
//   x    [W-1:0]  upper half of the accumulator
//   y    [W-1:0]  masked multiplicand (or zero when the multiplier bit is 0)
//   sum  [W-1:0]  x + y, low W bits
//   cout          carry out of the top cell
// -----------------------------------------------------------------------------
module add_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry_s;

  assign carry_s[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]         = x[i] ^ y[i] ^ carry_s[i];
    assign carry_s[i + 1] = (x[i] & y[i]) | (carry_s[i] & (x[i] ^ y[i]));
  end

  assign cout = carry_s[W];

endmodule

// File: rtl/shift_add_mult_seq.sv
// -----------------------------------------------------------------------------
// shift_add_mult_seq
// Sequential unsigned W x W multiplier with optional truncation of the low
// approx_k product columns. One multiplier bit is consumed per cycle: the
// masked multiplicand is added into the top half of a 2W+1-bit accumulator,
// then the accumulator shifts right by one.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands offered            in_ready   accepting (IDLE)
//   a, b       unsigned operands           approx_k   low columns to drop
//   out_valid  product valid (DONE)        out_ready  downstream accepts
//   product    2W-bit result               busy       computing (RUN)
// -----------------------------------------------------------------------------
module shift_add_mult_seq
  import mult_seq_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [3:0]     approx_k,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int AW = 2 * W + 1;
  localparam int SW = $clog2(W + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(W - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [3:0]    k_q, k_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [SW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  mask_a_s;
  logic [W-1:0]  addend_s;
  logic [W-1:0]  sum_s;
  logic          cout_s;
  logic [AW-1:0] acc_step_s;

  // Truncation mask: multiplicand bit j in step i lands in column i+j.
  always_comb begin
    mask_a_s = {W{1'b0}};
    for (int j = 0; j < W; j++) begin
      if (col_kept(int'(cnt_q) + j, k_q)) begin
        mask_a_s[j] = a_q[j];
      end else begin
        mask_a_s[j] = 1'b0;
      end
    end
  end

  // Adder operand: b_q is shifted each step, so bit 0 is the current multiplier bit.
  always_comb begin
    if (b_q[0]) begin
      addend_s = mask_a_s;
    end else begin
      addend_s = {W{1'b0}};
    end
  end

  add_row #(.W(W)) u_add_row (
    .x    (acc_q[2*W-1:W]),
    .y    (addend_s),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Add-then-shift in one step. The top accumulator bit only ever reloads
  // itself, so it stays zero from the clear; the adder carry lands one below it.
  assign acc_step_s = {acc_q[AW-1], cout_s, sum_s, acc_q[W-1:1]};

  // Controller next-state and datapath load/step selection.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          k_d   = approx_k;
          acc_d = {AW{1'b0}};
          cnt_d = {SW{1'b0}};
          // A zero operand needs no iterations: the cleared accumulator is the answer.
          if ((a == {W{1'b0}}) || (b == {W{1'b0}})) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = acc_step_s;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + SW'(1'b1);
        if (cnt_q == LAST_STEP) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      k_q     <= 4'd0;
      acc_q   <= {AW{1'b0}};
      cnt_q   <= {SW{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status outputs are the one-hot state flops; the product is the held accumulator.
  assign in_ready  = state_q[0];
  assign busy      = state_q[1];
  assign out_valid = state_q[2];
  assign product   = acc_q[2*W-1:0];

endmodule

// File: doc/shift_add_mult_seq.md
SHIFT_ADD_MULT_SEQ -- requirements
Module: shift_add_mult_seq

Interface
REQ-001 Parameter: W, default 8, operand width in bits; the product is 2W bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand request from the upstream side.
REQ-005 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 a  input  W  multiplicand, unsigned.
REQ-007 b  input  W  multiplier, unsigned.
REQ-008 approx_k  input  4  count of low product columns to truncate; 0 gives the exact product.
REQ-009 out_valid  output  1  product is valid; high only in DONE.
REQ-010 out_ready  input  1  downstream accepts the product.
REQ-011 product  output  2W  result; stable while out_valid is high.
REQ-012 busy  output  1  high in RUN.

Function
REQ-013 The FSM SHALL have three states (IDLE, RUN, DONE), one-hot or binary encoded.
REQ-014 IDLE: input handshake is in_valid & in_ready; on handshake, a, b and approx_k SHALL be latched, the 2W+1-bit accumulator cleared, and the step counter cleared.
REQ-015 IDLE->RUN on handshake when a!=0 and b!=0; IDLE->DONE with product=0 when a==0 or b==0, giving 1-cycle latency.
REQ-016 RUN step i (0..W-1): if b_reg[i]=1, the masked multiplicand SHALL be added to acc[2W:W] through the W-bit adder row; then acc SHALL shift right by 1.
REQ-017 Mask: bit j of the multiplicand SHALL be zeroed in step i when i+j < approx_k, so every partial-product bit in columns 0..approx_k-1 is dropped.
REQ-018 Consequence: product[approx_k-1:0]==0 for approx_k>=1; approx_k values up to 15 are legal with no clamping.
REQ-019 RUN->DONE after exactly W steps; with an input handshake at cycle 0, out_valid SHALL rise at cycle W+1.
REQ-020 DONE: product SHALL hold acc[2W-1:0]; DONE->IDLE on out_valid & out_ready; out_valid SHALL fall the next cycle.
REQ-021 Backpressure: while out_ready=0, DONE SHALL persist indefinitely with product unchanged.
REQ-022 in_valid in RUN or DONE SHALL be ignored; operands are not queued.
REQ-023 The latched approx_k SHALL govern the whole operation; changes on the approx_k input mid-operation have no effect.

Reset
REQ-024 rst_n low SHALL force IDLE at once: in_ready=1, out_valid=0, busy=0, product=0, acc=0, counter=0.
REQ-025 Reset during RUN or DONE SHALL abandon the operation and emit no product.
REQ-026 The first handshake after rst_n deasserts SHALL be accepted on the first rising edge with in_valid=1.

Structure
REQ-027 Package mult_seq_pkg SHALL hold the W default, ACC_W=2W+1, the state typedef and the step-counter width $clog2(W+1).
REQ-028 The adder row SHALL be one sub-module, add_row, containing W ripple-chained one-bit full-adder cells (carry_in=0, carry_out into acc[2W]).
REQ-029 The mask generation and the FSM SHALL stay in shift_add_mult_seq; no other sub-modules.

Verification
REQ-030 a=13, b=11, k=0, handshake at cycle 0 -> out_valid at cycle 9, product=143.
REQ-031 a=255, b=255, k=0 -> product=65025 (0xFE01); with k=4 -> product=64976 (0xFDD0), low nibble 0.
REQ-032 a=0, b=200, k=0 -> DONE next cycle, product=0, busy never high.
REQ-033 a=7, b=9, out_ready held 0 for 3 cycles after out_valid -> product=63 held steady; in_valid pulses in that window are ignored; IDLE reached after out_ready=1.
REQ-034 rst_n pulsed low at step 4 of RUN -> outputs at reset values that cycle, no out_valid; next handshake a=3, b=5 -> product=15.
REQ-035 Random a, b, k (10k ops) vs reference model sum over i+j>=k of a[j]b[i]2^(i+j) -> exact match; product[k-1:0]==0 whenever k>=1.
